// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a synchronous byte FIFO drained by a serialiser
// that advances only on the shared 16x oversampled baud_tick enable.
module uart_tx_fifo #(
  parameter int DEPTH      = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     baud_tick,
  input  logic                     push,
  input  logic [7:0]               push_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     tx,
  output logic                     tx_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state;
  logic [DEPTH-1:0][7:0]  mem;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          cnt;
  logic [TW-1:0]          tick_cnt;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift;
  logic                   accept, pop, bit_end;

  assign count   = cnt;
  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  // Acceptance looks only at registered full, so a same-cycle pop never frees a slot.
  assign accept  = push & ~full;
  assign bit_end = baud_tick && (tick_cnt == TW'(OVERSAMPLE - 1));
  assign pop     = ~empty & ((state == IDLE) | ((state == STOP) & bit_end));

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push & full;
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(accept) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      shift    <= '0;
      bit_cnt  <= '0;
      tick_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          if (pop) begin
            shift    <= mem[rd_ptr];
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            tick_cnt <= '0;
            state    <= START;
          end
        end
        START: if (baud_tick) begin
          if (bit_end) begin
            tick_cnt <= '0;
            tx       <= shift[0];
            bit_cnt  <= '0;
            state    <= DATA;
          end else tick_cnt <= tick_cnt + TW'(1);
        end
        DATA: if (baud_tick) begin
          if (bit_end) begin
            tick_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shift[1];
            end
          end else tick_cnt <= tick_cnt + TW'(1);
        end
        STOP: if (baud_tick) begin
          if (bit_end) begin
            tick_cnt <= '0;
            // Chain straight into the next start bit so tx_busy never drops.
            if (pop) begin
              shift <= mem[rd_ptr];
              tx    <= 1'b0;
              state <= START;
            end else begin
              tx_busy <= 1'b0;
              state   <= IDLE;
            end
          end else tick_cnt <= tick_cnt + TW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: pushed bytes queue their expected frames; a line monitor
// decodes tx at mid-bit and checks each frame against the queue.
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       push = 1'b0;
  logic [7:0] push_data = '0;
  logic       full, empty, overflow, tx, tx_busy;
  logic [4:0] count;

  int   n_chk = 0, n_fail = 0, ovf_cnt = 0;
  logic [7:0] exp_q[$];

  uart_tx_fifo #(.DEPTH(16), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .push(push), .push_data(push_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input bit sent);
    push = 1'b1; push_data = d;
    if (sent) exp_q.push_back(d);
    step();
    push = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      baud_tick = 1'b1; step();
      baud_tick = 1'b0; step();
    end
  endtask

  // Line monitor: tick 8 of each 16-tick slot is mid-bit; slot 0 start, 1..8 data, 9 stop.
  initial begin
    bit       in_frame = 0;
    logic     prev_tx  = 1'b1;
    int       tcnt     = 0;
    logic [9:0] frame  = '0;
    forever begin
      @(negedge clk);
      if (overflow) ovf_cnt++;
      if (!rst) begin
        in_frame = 0; prev_tx = 1'b1;
      end else begin
        if (!in_frame && prev_tx && !tx) begin in_frame = 1; tcnt = 0; end
        if (in_frame && baud_tick) begin
          tcnt++;
          if (tcnt % 16 == 8) begin
            frame[tcnt/16] = tx;
            chk("busy_in_frame", tx_busy, 1'b1);
            if (tcnt / 16 == 9) begin
              in_frame = 0;
              chk("start_bit", frame[0], 1'b0);
              chk("stop_bit", frame[9], 1'b1);
              n_chk++;
              if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_frame: got %0h expected none", frame[8:1]);
              end else chk("frame_data", frame[8:1], exp_q.pop_front());
            end
          end
        end
        prev_tx = tx;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b0;
    #5;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_count", count, 5'd0);
    chk("rst_ovf", overflow, 1'b0);
    step(); step();
    rst = 1'b1;

    ticks(500);
    chk("idle_tx", tx, 1'b1);
    chk("idle_busy", tx_busy, 1'b0);
    chk("idle_empty", empty, 1'b1);
    chk("idle_count", count, 5'd0);
    chk("idle_ovf_cnt", ovf_cnt, 0);

    // Single frame: 0x55
    push_byte(8'h55, 1);
    chk("p55_empty", empty, 1'b0);
    chk("p55_count", count, 5'd1);
    step();
    chk("p55_pop_empty", empty, 1'b1);
    chk("p55_tx_start", tx, 1'b0);
    chk("p55_busy", tx_busy, 1'b1);
    ticks(159);
    chk("p55_busy_159", tx_busy, 1'b1);
    chk("p55_stop_tx", tx, 1'b1);
    ticks(1);
    chk("p55_busy_160", tx_busy, 1'b0);

    // Three back-to-back frames
    push_byte(8'hA3, 1); chk("b3_count0", count, 5'd1);
    push_byte(8'h0F, 1); chk("b3_count1", count, 5'd1);
    push_byte(8'hFF, 1); chk("b3_count2", count, 5'd2);
    ticks(160);
    chk("b3_count_f1", count, 5'd1);
    chk("b3_nogap_tx", tx, 1'b0);
    chk("b3_busy_f1", tx_busy, 1'b1);
    ticks(160);
    chk("b3_count_f2", count, 5'd0);
    ticks(159);
    chk("b3_busy_479", tx_busy, 1'b1);
    ticks(1);
    chk("b3_busy_480", tx_busy, 1'b0);

    // Stalled line: 0xEE occupies the shifter, then fill FIFO and overflow
    push_byte(8'hEE, 1);
    step();
    chk("st_count0", count, 5'd0);
    chk("st_busy", tx_busy, 1'b1);
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1);
    chk("st_count16", count, 5'd16);
    chk("st_full", full, 1'b1);
    push_byte(8'h10, 0);
    chk("st_ovf", overflow, 1'b1);
    chk("st_ovf_count", count, 5'd16);
    step();
    chk("st_ovf_clr", overflow, 1'b0);

    // Push while full on the STOP->START pop edge is still dropped
    ticks(159);
    baud_tick = 1'b1; push = 1'b1; push_data = 8'h77;
    step();
    baud_tick = 1'b0; push = 1'b0;
    chk("fp_ovf", overflow, 1'b1);
    chk("fp_count", count, 5'd15);
    chk("fp_tx", tx, 1'b0);
    chk("fp_busy", tx_busy, 1'b1);
    step();
    ticks(160*16 - 1);
    chk("drain_busy", tx_busy, 1'b1);
    ticks(1);
    chk("drain_busy_end", tx_busy, 1'b0);
    chk("drain_empty", empty, 1'b1);
    chk("drain_q_left", exp_q.size(), 0);

    // Async reset mid-DATA with bytes queued
    push_byte(8'hC3, 0); chk("mr_count0", count, 5'd1);
    push_byte(8'h11, 0); chk("mr_count1", count, 5'd1);
    push_byte(8'h22, 0); chk("mr_count2", count, 5'd2);
    push_byte(8'h33, 0); chk("mr_count3", count, 5'd3);
    ticks(40);
    chk("mr_busy_pre", tx_busy, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("mr_tx", tx, 1'b1);
    chk("mr_busy", tx_busy, 1'b0);
    chk("mr_count", count, 5'd0);
    chk("mr_empty", empty, 1'b1);
    step(); step();
    rst = 1'b1;
    ticks(200);
    chk("mr_post_tx", tx, 1'b1);
    chk("mr_post_busy", tx_busy, 1'b0);
    chk("mr_post_count", count, 5'd0);
    chk("ovf_total", ovf_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
